// File: rtl/seq_mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_pkg
// Brief    : Shared types and sizing helpers for the shift-add multiplier
//            sequencing controller.
// Revision : 1.0 - initial release
// ============================================================================
package seq_mult_pkg;

    localparam int SEQ_MULT_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        RUN    = 3'd2,
        SETTLE = 3'd3,
        DONE   = 3'd4
    } seq_mult_state_e;

    function automatic int seq_mult_opw(input int width);
        return width / 2;
    endfunction

    // Guarded so a degenerate 2-bit product still gets a 1-bit counter.
    function automatic int seq_mult_cnt_w(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/seq_mult_opreg.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_opreg
// Brief    : Paired operand shift register: multiplicand shifts left in the
//            full product width, multiplier shifts right one bit per step.
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_opreg
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH_P = SEQ_MULT_WIDTH,
    localparam int OPW     = seq_mult_opw(WIDTH_P)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic               shift,
    input  logic [OPW-1:0]     mcand_in,
    input  logic [OPW-1:0]     mplr_in,
    output logic [WIDTH_P-1:0] mcand,
    output logic               mplr_lsb,
    output logic               mplr_next_zero
);

    logic [WIDTH_P-1:0] r_mcand;
    logic [OPW-1:0]     r_mplr;
    logic [OPW-1:0]     w_mplr_shifted;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mcand <= '0;
            r_mplr  <= '0;
        end else if (load) begin
            r_mcand <= {{(WIDTH_P - OPW){1'b0}}, mcand_in};
            r_mplr  <= mplr_in;
        end else if (shift) begin
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
        end
    end

    // Zero flag looks one step ahead so the controller can stop on this edge.
    assign w_mplr_shifted = r_mplr >> 1;
    assign mplr_next_zero = (w_mplr_shifted == '0);
    assign mplr_lsb       = r_mplr[0];
    assign mcand          = r_mcand;

endmodule
`default_nettype wire

// File: rtl/seq_mult_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : seq_mult_ctrl
// Brief    : Sequencing controller for the shift-add multiplier; drives the
//            external accumulator and captures its result.
// Config   : SEQ_MULT_EARLY_EXIT_EN - leave RUN once no multiplier bits remain
// Revision : 1.0 - initial release
// ============================================================================
module seq_mult_ctrl
    import seq_mult_pkg::*;
#(
    parameter  int WIDTH_P = SEQ_MULT_WIDTH,
    localparam int OPW     = seq_mult_opw(WIDTH_P)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               ready,
    input  logic [OPW-1:0]     multiplicand,
    input  logic [OPW-1:0]     multiplier,
    output logic               busy,
    output logic               flush,
    output logic               add_shift,
    output logic [WIDTH_P-1:0] addend,
    input  logic [WIDTH_P-1:0] acc_result,
    output logic [WIDTH_P-1:0] product,
    output logic               done
);

    localparam int               CNT_W      = seq_mult_cnt_w(WIDTH_P);
    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(OPW - 1);
`ifdef SEQ_MULT_EARLY_EXIT_EN
    localparam bit               c_early_exit = 1'b1;
`else
    localparam bit               c_early_exit = 1'b0;
`endif

    seq_mult_state_e    r_state;
    seq_mult_state_e    w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH_P-1:0] r_product;
    logic [WIDTH_P-1:0] w_mcand;
    logic               w_mplr_lsb;
    logic               w_mplr_next_zero;
    logic               w_accept;
    logic               w_shift;
    logic               w_run_exit;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_shift    = (r_state == RUN);
    assign w_run_exit = (r_cnt == c_cnt_last) || (c_early_exit && w_mplr_next_zero);

    seq_mult_opreg #(
        .WIDTH_P        (WIDTH_P)
    ) u_opreg (
        .clk            (clk),
        .reset          (reset),
        .load           (w_accept),
        .shift          (w_shift),
        .mcand_in       (multiplicand),
        .mplr_in        (multiplier),
        .mcand          (w_mcand),
        .mplr_lsb       (w_mplr_lsb),
        .mplr_next_zero (w_mplr_next_zero)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_accept) begin
            r_cnt <= '0;
        end else if (w_shift) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // The accumulator has already absorbed the last RUN update by DONE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_product <= '0;
        end else if (r_state == DONE) begin
            r_product <= acc_result;
        end
    end

    assign product = r_product;

    always_comb begin
        w_state_next = r_state;
        ready        = 1'b0;
        busy         = 1'b1;
        flush        = 1'b0;
        add_shift    = 1'b0;
        addend       = '0;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                ready = 1'b1;
                busy  = 1'b0;
                if (start) begin
                    w_state_next = CLEAR;
                end
            end
            CLEAR: begin
                flush        = 1'b1;
                w_state_next = RUN;
            end
            RUN: begin
                add_shift    = w_mplr_lsb;
                addend       = w_mcand;
                w_state_next = w_run_exit ? SETTLE : RUN;
            end
            SETTLE: begin
                w_state_next = DONE;
            end
            DONE: begin
                done         = 1'b1;
                w_state_next = IDLE;
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire
